// File: rtl/nn_pkg.sv
// Shared types, fixed-point constants, sigmoid PWL segments and FSM states for dense_layer_argmax.
package nn_pkg;

    typedef logic signed [15:0] q8_8_t;
    typedef logic [7:0]         q0_8_t;

    localparam int unsigned Q_FRAC = 8;

    // Sigmoid saturation thresholds (+/-5.0 in Q8.8)
    localparam q8_8_t SIG_SAT_POS = 16'sh0500;
    localparam q8_8_t SIG_SAT_NEG = -16'sh0500;

    // PWL breakpoints on |x|: [0,1.0), [1.0,2.375), [2.375,5.0)
    localparam q8_8_t SIG_BP1 = 16'sh0100;
    localparam q8_8_t SIG_BP2 = 16'sh0260;

    // Segment slopes as right shifts (1/4, 1/8, 1/32) and Q0.8 intercepts (0.5, 0.625, 0.84375)
    localparam int unsigned SIG_SH0 = 2;
    localparam int unsigned SIG_SH1 = 3;
    localparam int unsigned SIG_SH2 = 5;
    localparam logic [8:0]  SIG_B0  = 9'd128;
    localparam logic [8:0]  SIG_B1  = 9'd160;
    localparam logic [8:0]  SIG_B2  = 9'd216;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_BIAS,
        ST_ACT,
        ST_ARGMAX,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/dense_layer_argmax_sigmoid_pwl.sv
// Combinational piecewise-linear sigmoid, Q8.8 in -> Q0.8 out.
// Evaluated on |x| and mirrored (1 - f) for negative inputs, so the curve is odd-symmetric about 0.5.
module sigmoid_pwl
    import nn_pkg::*;
(
    input  q8_8_t i_x,
    output q0_8_t o_y
);

    logic [15:0] w_mag;
    logic [8:0]  w_pos;

    // Segment select on magnitude, then saturate / mirror by sign
    always_comb begin
        w_mag = 16'd0;
        w_pos = SIG_B0;
        o_y   = 8'h80;
        w_mag = i_x[15] ? 16'(-i_x) : 16'(i_x);
        if (w_mag < $unsigned(SIG_BP1)) begin
            w_pos = 9'(w_mag >> SIG_SH0) + SIG_B0;
        end else if (w_mag < $unsigned(SIG_BP2)) begin
            w_pos = 9'(w_mag >> SIG_SH1) + SIG_B1;
        end else begin
            w_pos = 9'(w_mag >> SIG_SH2) + SIG_B2;
        end
        if (i_x >= SIG_SAT_POS) begin
            o_y = 8'hFF;
        end else if (i_x <= SIG_SAT_NEG) begin
            o_y = 8'h00;
        end else if (i_x[15]) begin
            o_y = 8'(9'd256 - w_pos);
        end else begin
            o_y = w_pos[7:0];
        end
    end

endmodule

// File: rtl/dense_layer_argmax.sv
// Dense layer (N_OUT neurons over N_IN streamed Q8.8 inputs) + PWL sigmoid + sequential argmax.
// Optional build macro: SATURATE_ACC_EN (saturating MAC accumulate; default wraps modulo 2^ACC_W).
module dense_layer_argmax
    import nn_pkg::*;
#(
    parameter int unsigned N_IN  = 784,
    parameter int unsigned N_OUT = 10,
    parameter int unsigned ACC_W = 32 + $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [15:0]             pix_data,
    output logic [$clog2(N_IN)-1:0] w_addr,
    output logic                    w_rden,
    input  logic [16*N_OUT-1:0]     w_data,
    input  logic [16*N_OUT-1:0]     bias,
    output logic [8*N_OUT-1:0]      act_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [3:0]              pred_class,
    output logic [7:0]              pred_conf,
    output logic                    busy
);

    localparam int unsigned CNT_W = $clog2(N_IN);
    localparam int unsigned IDX_W = $clog2(N_OUT);
    localparam int unsigned PB_W  = ACC_W + 1;
    localparam logic signed [PB_W-1:0] PRE_MAX = PB_W'(32'sd32767);
    localparam logic signed [PB_W-1:0] PRE_MIN = PB_W'(-32'sd32768);
`ifdef SATURATE_ACC_EN
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    state_t                   r_state;
    state_t                   w_next;
    logic [CNT_W-1:0]         r_count;
    logic                     r_last_d;
    logic                     r_mac_en;
    q8_8_t                    r_pix_d;
    logic                     r_pix_ready;
    logic                     r_res_valid;
    logic                     r_busy;
    logic [IDX_W-1:0]         r_scan;
    logic [IDX_W-1:0]         r_best_idx;
    q0_8_t                    r_best_val;
    logic                     w_accept;
    logic                     w_last;

    logic signed [ACC_W-1:0]  r_acc     [N_OUT];
    logic signed [ACC_W-1:0]  w_acc_nxt [N_OUT];
    q8_8_t                    w_wt      [N_OUT];
    logic signed [31:0]       w_prod    [N_OUT];
`ifdef SATURATE_ACC_EN
    logic signed [SUM_W-1:0]  w_sum     [N_OUT];
`endif
    logic signed [PB_W-1:0]   w_pb      [N_OUT];
    logic signed [PB_W-1:0]   w_sh      [N_OUT];
    q8_8_t                    w_pre     [N_OUT];
    q8_8_t                    r_pre     [N_OUT];
    q0_8_t                    w_sig     [N_OUT];
    q0_8_t                    r_act     [N_OUT];

    assign w_accept   = pix_valid && r_pix_ready;
    assign w_last     = w_accept && (r_count == CNT_W'(N_IN - 1));
    assign w_rden     = w_accept;
    assign w_addr     = r_count;
    assign pix_ready  = r_pix_ready;
    assign res_valid  = r_res_valid;
    assign busy       = r_busy;
    assign pred_class = 4'(r_best_idx);
    assign pred_conf  = r_best_val;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; ACCUM lingers one cycle after the last accept to finish the final MAC
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_ACCUM;
            ST_ACCUM:  if (r_last_d) w_next = ST_BIAS;
            ST_BIAS:   w_next = ST_ACT;
            ST_ACT:    w_next = ST_ARGMAX;
            ST_ARGMAX: if (r_scan == IDX_W'(N_OUT - 1)) w_next = ST_HOLD;
            ST_HOLD:   if (r_res_valid && res_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Input capture, address counter and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_last_d    <= 1'b0;
            r_mac_en    <= 1'b0;
            r_pix_d     <= '0;
            r_pix_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_mac_en    <= w_accept;
            r_last_d    <= w_last;
            if (w_accept) begin
                r_pix_d <= q8_8_t'(pix_data);
                r_count <= w_last ? '0 : r_count + 1'b1;
            end
            r_pix_ready <= ((w_next == ST_IDLE) || (w_next == ST_ACCUM)) && !w_last;
            r_res_valid <= (w_next == ST_HOLD);
            r_busy      <= (w_next != ST_IDLE);
        end
    end

    // MAC datapath: Q16.16 product sign-extended into the accumulator
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            w_wt[k]   = q8_8_t'(w_data[16*k +: 16]);
            w_prod[k] = 32'(r_pix_d) * 32'(w_wt[k]);
`ifdef SATURATE_ACC_EN
            w_sum[k] = SUM_W'(r_acc[k]) + SUM_W'(w_prod[k]);
            if (w_sum[k][SUM_W-1] != w_sum[k][SUM_W-2]) begin
                w_acc_nxt[k] = w_sum[k][SUM_W-1] ? ACC_MIN : ACC_MAX;
            end else begin
                w_acc_nxt[k] = w_sum[k][ACC_W-1:0];
            end
`else
            w_acc_nxt[k] = r_acc[k] + ACC_W'(w_prod[k]);
`endif
        end
    end

    // Accumulators: cleared on reset and in ACT, updated one cycle after each accept
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_OUT; k++) begin
            if (reset || (r_state == ST_ACT)) begin
                r_acc[k] <= '0;
            end else if (r_mac_en) begin
                r_acc[k] <= w_acc_nxt[k];
            end
        end
    end

    // Bias add, rescale Q.16 -> Q.8 and saturate to 16 bits
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            w_pb[k] = PB_W'(r_acc[k]) + (PB_W'(q8_8_t'(bias[16*k +: 16])) <<< Q_FRAC);
            w_sh[k] = w_pb[k] >>> Q_FRAC;
            if (w_sh[k] > PRE_MAX) begin
                w_pre[k] = 16'sh7FFF;
            end else if (w_sh[k] < PRE_MIN) begin
                w_pre[k] = 16'sh8000;
            end else begin
                w_pre[k] = w_sh[k][15:0];
            end
        end
    end

    // Pre-activation (BIAS) and activation (ACT) registers
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_OUT; k++) begin
            if (reset) begin
                r_pre[k] <= '0;
                r_act[k] <= '0;
            end else begin
                if (r_state == ST_BIAS) r_pre[k] <= w_pre[k];
                if (r_state == ST_ACT)  r_act[k] <= w_sig[k];
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_neuron
        sigmoid_pwl u_sig (
            .i_x (r_pre[k]),
            .o_y (w_sig[k])
        );
        assign act_out[8*k +: 8] = r_act[k];
    end

    // Argmax scan: seeded with neuron 0 in ACT, one strict compare per ARGMAX cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan     <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
        end else if (r_state == ST_ACT) begin
            r_scan     <= IDX_W'(1);
            r_best_idx <= '0;
            r_best_val <= w_sig[0];
        end else if (r_state == ST_ARGMAX) begin
            r_scan <= r_scan + 1'b1;
            if (r_act[r_scan] > r_best_val) begin
                r_best_idx <= r_scan;
                r_best_val <= r_act[r_scan];
            end
        end
    end

endmodule

// File: tb/tb_dense_layer_argmax.sv
// Bench for dense_layer_argmax: directed frames, expected results queued by the driver,
// popped and compared by an independent monitor when res_valid rises.
module tb_dense_layer_argmax;

    localparam int N_IN  = 784;
    localparam int N_OUT = 10;
    localparam int CNT_W = 10;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [15:0]           pix_data;
    logic [CNT_W-1:0]      w_addr;
    logic                  w_rden;
    logic [16*N_OUT-1:0]   w_data;
    logic [16*N_OUT-1:0]   bias;
    logic [8*N_OUT-1:0]    act_out;
    logic                  res_valid;
    logic                  res_ready;
    logic [3:0]            pred_class;
    logic [7:0]            pred_conf;
    logic                  busy;

    typedef struct {
        logic [8*N_OUT-1:0] act;
        logic [3:0]         cls;
        logic [7:0]         conf;
        int unsigned        t_last;
    } exp_t;

    exp_t                sb_q[$];
    int unsigned         cyc = 0;
    int                  n_chk = 0;
    int                  n_pass = 0;
    int                  n_pushed = 0;
    int                  n_results = 0;
    int                  rr_delay = 0;
    int                  w_lim = N_IN;
    logic [16*N_OUT-1:0] w_row;

    dense_layer_argmax u_dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .w_addr     (w_addr),
        .w_rden     (w_rden),
        .w_data     (w_data),
        .bias       (bias),
        .act_out    (act_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .pred_class (pred_class),
        .pred_conf  (pred_conf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory: one-cycle read latency, rows at or beyond w_lim read as zero
    always @(posedge clk) begin
        if (w_rden) w_data <= (int'(w_addr) < w_lim) ? w_row : '0;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    function automatic logic [8*N_OUT-1:0] fill(input logic [7:0] v);
        logic [8*N_OUT-1:0] r;
        for (int k = 0; k < N_OUT; k++) r[8*k +: 8] = v;
        return r;
    endfunction

    function automatic logic [16*N_OUT-1:0] fill16(input logic [15:0] v);
        logic [16*N_OUT-1:0] r;
        for (int k = 0; k < N_OUT; k++) r[16*k +: 16] = v;
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_ready"},  pix_ready,  1);
        check({tag, "_w_rden"},     w_rden,     0);
        check({tag, "_w_addr"},     w_addr,     0);
        check({tag, "_res_valid"},  res_valid,  0);
        check({tag, "_pred_class"}, pred_class, 0);
        check({tag, "_pred_conf"},  pred_conf,  0);
        check({tag, "_act_out"},    act_out,    0);
        check({tag, "_busy"},       busy,       0);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || res_valid || sb_q.size() != 0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) check("idle_timeout", 1, 0);
    endtask

    task automatic drive_frame(input logic [15:0] pix, input bit toggle, input int n_acc,
                               output int unsigned t_last);
        t_last = 0;
        for (int i = 0; i < n_acc; i++) begin
            if (toggle) begin
                pix_valid = 1'b0;
                @(negedge clk);
            end
            pix_valid = 1'b1;
            pix_data  = pix;
            for (int g = 0; g < 2000 && !pix_ready; g++) @(negedge clk);
            if (!pix_ready) begin
                $display("FAIL pix_ready_timeout: got 0 required 1");
                $display("%0d/%0d checks passed", n_pass, n_chk + 1);
                $fatal(1);
            end
            t_last = cyc;
            @(negedge clk);
        end
        pix_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] pix, input bit toggle, input int delay,
                             input logic [8*N_OUT-1:0] e_act, input logic [3:0] e_cls,
                             input logic [7:0] e_conf);
        exp_t e;
        int unsigned t;
        rr_delay = delay;
        drive_frame(pix, toggle, N_IN, t);
        e.act = e_act; e.cls = e_cls; e.conf = e_conf; e.t_last = t;
        sb_q.push_back(e);
        n_pushed++;
    endtask

    // Consumer: raises res_ready once the result has been held for rr_delay cycles
    initial begin
        int hold_cnt;
        hold_cnt  = 0;
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (res_valid) begin
                if (hold_cnt >= rr_delay) res_ready = 1'b1;
                hold_cnt++;
            end else begin
                res_ready = 1'b0;
                hold_cnt  = 0;
            end
        end
    end

    // Monitor: compare on res_valid rise, then watch the held outputs until res_valid falls
    initial begin
        exp_t               e;
        logic               prev_v;
        logic [8*N_OUT-1:0] cap_act;
        logic [3:0]         cap_cls;
        logic [7:0]         cap_conf;
        int                 hold_bad;
        prev_v = 1'b0; hold_bad = 0;
        cap_act = '0; cap_cls = '0; cap_conf = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
            end else begin
                if (res_valid && !prev_v) begin
                    hold_bad = 0;
                    if (sb_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("act_out",    act_out,    e.act);
                        check("pred_class", pred_class, e.cls);
                        check("pred_conf",  pred_conf,  e.conf);
                        check("latency",    cyc - e.t_last, N_OUT + 3);
                    end
                    cap_act = act_out; cap_cls = pred_class; cap_conf = pred_conf;
                end
                if (res_valid) begin
                    if (act_out !== cap_act || pred_class !== cap_cls || pred_conf !== cap_conf ||
                        pix_ready !== 1'b0 || busy !== 1'b1) hold_bad++;
                end
                if (!res_valid && prev_v) begin
                    check("hold_stable", hold_bad, 0);
                    n_results++;
                end
                prev_v = res_valid;
            end
        end
    end

    initial begin
        logic [8*N_OUT-1:0] ea;
        int unsigned        t;
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_data  = '0;
        bias      = '0;
        w_row     = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        reset = 1'b0;
        @(negedge clk);

        // Zero weights/bias: every neuron at sigmoid(0), tie resolved to class 0
        run_frame(16'h0100, 1'b0, 0, fill(8'h80), 4'd0, 8'h80);

        // Neuron 7 weight 1/256: pre = 0x0310 -> 0xF0
        wait_idle();
        w_row = '0; w_row[16*7 +: 16] = 16'h0001;
        ea = fill(8'h80); ea[8*7 +: 8] = 8'hF0;
        run_frame(16'h0100, 1'b0, 0, ea, 4'd7, 8'hF0);

        // Bias-only: neuron 3 saturates high, others saturate low
        wait_idle();
        w_row = '0;
        bias = fill16(16'hFA00); bias[16*3 +: 16] = 16'h0600;
        ea = fill(8'h00); ea[8*3 +: 8] = 8'hFF;
        run_frame(16'h0100, 1'b0, 0, ea, 4'd3, 8'hFF);

        // Bubbles on every other input and a slow consumer
        wait_idle();
        bias = '0;
        run_frame(16'h0100, 1'b1, 20, fill(8'h80), 4'd0, 8'h80);

        // Reset after 400 accepts, then a clean frame
        wait_idle();
        w_row = '0; w_row[16*7 +: 16] = 16'h0001;
        rr_delay = 0;
        drive_frame(16'h0100, 1'b0, 400, t);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        reset = 1'b0;
        @(negedge clk);
        ea = fill(8'h80); ea[8*7 +: 8] = 8'hF0;
        run_frame(16'h0100, 1'b0, 0, ea, 4'd7, 8'hF0);

        // Negative inputs over the first 392 rows: neuron 4 -> -0x188, neuron 9 -> +0x188
        wait_idle();
        w_lim = 392;
        w_row = '0; w_row[16*4 +: 16] = 16'h0001; w_row[16*9 +: 16] = 16'hFFFF;
        ea = fill(8'h80); ea[8*4 +: 8] = 8'h2F; ea[8*9 +: 8] = 8'hD1;
        run_frame(16'hFF00, 1'b0, 0, ea, 4'd9, 8'hD1);

        // Tie between neurons 2 and 5 at saturation: lowest index wins
        wait_idle();
        w_lim = N_IN;
        w_row = '0; w_row[16*2 +: 16] = 16'h0002; w_row[16*5 +: 16] = 16'h0002;
        ea = fill(8'h80); ea[8*2 +: 8] = 8'hFF; ea[8*5 +: 8] = 8'hFF;
        run_frame(16'h0100, 1'b0, 0, ea, 4'd2, 8'hFF);

        wait_idle();
        repeat (5) @(negedge clk);
        check("result_count", n_results, n_pushed);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
